// File: rtl/ps2_wb8.sv
// ps2_wb8: Wishbone8 slave that receives PS/2 device-to-host frames into a byte FIFO
// with sticky error flags and a level interrupt.
module ps2_wb8 #(
    parameter int CLOCKFREQ       = 25125000,
    parameter int TIMEOUT_CYCLES  = CLOCKFREQ / 1000,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic [7:0] O_wb_dat,
    output logic       O_wb_ack,
    input  logic       I_ps2_clk,
    input  logic       I_ps2_data,
    output logic       O_interrupt
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t       r_state, w_state_nxt;
    logic [2:0]   r_clk_sync;
    logic [1:0]   r_dat_sync;
    logic [2:0]   r_bitcnt;
    logic [7:0]   r_shift;
    logic         r_par_ok;
    logic [TW-1:0] r_tcnt;
    logic [7:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count, w_count_nxt;
    logic         r_ovf, r_perr, r_ferr, r_irq_en, r_ack, r_irq;
    logic [7:0]   r_rdat, w_rdata, w_status;
    logic         w_fall, w_dat, w_timeout, w_push, w_perr_set, w_ferr_set;
    logic         w_acc, w_rd, w_wr, w_pop, w_flush, w_stw, w_push_ok, w_ovf_set;
    logic         w_full, w_empty, w_irq_en_nxt, w_unused;

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != S_IDLE) && (r_tcnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr_set  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   w_state_nxt = w_dat ? S_IDLE : S_DATA;
                S_DATA:   w_state_nxt = (r_bitcnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_ferr_set  = ~w_dat;
                    w_push      = w_dat & r_par_ok;
                    w_perr_set  = w_dat & ~r_par_ok;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], I_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], I_ps2_data};
            r_state    <= w_state_nxt;
            r_tcnt     <= (r_state == S_IDLE || w_fall || w_timeout) ? '0 : r_tcnt + 1'b1;
            if (w_fall && r_state == S_IDLE)
                r_bitcnt <= '0;
            if (w_fall && r_state == S_DATA) begin
                r_shift  <= {w_dat, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            // Odd parity over data plus parity bit marks a good frame
            if (w_fall && r_state == S_PARITY)
                r_par_ok <= ^{r_shift, w_dat};
        end
    end

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_acc        = I_wb_stb & ~r_ack;
    assign w_rd         = w_acc & ~I_wb_we;
    assign w_wr         = w_acc & I_wb_we;
    assign w_pop        = w_rd && (I_wb_adr == 2'd0) && !w_empty;
    assign w_flush      = w_wr && (I_wb_adr == 2'd3);
    assign w_stw        = w_wr && (I_wb_adr == 2'd1);
    assign w_push_ok    = w_push & ~w_flush & (~w_full | w_pop);
    assign w_ovf_set    = w_push & ~w_flush & w_full & ~w_pop;
    assign w_count_nxt  = w_flush ? '0 : r_count + CW'(w_push_ok) - CW'(w_pop);
    assign w_irq_en_nxt = w_stw ? I_wb_dat[7] : r_irq_en;
    assign w_status     = {r_irq_en, 2'b00, r_ferr, r_perr, r_ovf, w_full, ~w_empty};
    assign w_unused     = ^{I_wb_dat[6:5], I_wb_dat[1:0]};

    always_comb begin
        w_rdata = (I_wb_adr == 2'd0) ? (w_empty ? 8'h00 : r_mem[r_rd]) :
                  (I_wb_adr == 2'd1) ? w_status :
                  (I_wb_adr == 2'd2) ? 8'(r_count) : 8'h00;
    end

    always_ff @(posedge I_wb_clk) begin
        if (w_push_ok)
            r_mem[r_wr] <= r_shift;
    end

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_irq_en <= 1'b0;
            r_ack    <= 1'b0;
            r_rdat   <= 8'h00;
            r_irq    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push_ok)
                    r_wr <= r_wr + 1'b1;
                if (w_pop)
                    r_rd <= r_rd + 1'b1;
            end
            r_count  <= w_count_nxt;
            // A flag raised in the same cycle as its clear wins
            r_ovf    <= (r_ovf & ~(w_stw & I_wb_dat[2])) | w_ovf_set;
            r_perr   <= (r_perr & ~(w_stw & I_wb_dat[3])) | w_perr_set;
            r_ferr   <= (r_ferr & ~(w_stw & I_wb_dat[4])) | w_ferr_set;
            r_irq_en <= w_irq_en_nxt;
            r_ack    <= w_acc;
            if (w_rd)
                r_rdat <= w_rdata;
            r_irq    <= w_irq_en_nxt & (w_count_nxt != '0);
        end
    end

    assign O_wb_dat    = r_rdat;
    assign O_wb_ack    = r_ack;
    assign O_interrupt = r_irq;
endmodule

// File: tb/tb_ps2_wb8.sv
// tb_ps2_wb8: scoreboard bench for ps2_wb8 driving PS/2 frames and Wishbone accesses
// against a queue-based model of the receive FIFO and flags.
module tb_ps2_wb8;
    localparam int H  = 10;
    localparam int TO = 200;
    localparam int DEPTH = 8;

    typedef struct {
        logic       chk;
        logic [7:0] exp;
        string      nm;
    } sb_t;

    logic       clk = 0, rst = 1;
    logic [1:0] adr = 0;
    logic [7:0] wdat = 0;
    logic       stb = 0, we = 0;
    logic [7:0] rdat;
    logic       ack, irq;
    logic       ps2_c = 1, ps2_d = 1;
    logic       irq4 = 0;

    int n_chk = 0, n_fail = 0;
    sb_t sb_q[$];
    sb_t mon_s;

    logic [7:0] m_q[$];
    logic       m_ovf = 0, m_perr = 0, m_ferr = 0, m_irq_en = 0;

    ps2_wb8 #(.CLOCKFREQ(200000), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH_LOG2(3)) dut (
        .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_dat(wdat),
        .I_wb_stb(stb), .I_wb_we(we), .O_wb_dat(rdat), .O_wb_ack(ack),
        .I_ps2_clk(ps2_c), .I_ps2_data(ps2_d), .O_interrupt(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: ack with no pending access");
            end else begin
                mon_s = sb_q.pop_front();
                if (mon_s.chk) begin
                    n_chk++;
                    if (rdat !== mon_s.exp) begin
                        n_fail++;
                        $display("FAIL %s: got %02h expected %02h", mon_s.nm, rdat, mon_s.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_status();
        return {m_irq_en, 2'b00, m_ferr, m_perr, m_ovf, m_q.size() == DEPTH, m_q.size() != 0};
    endfunction

    function automatic void m_frame(input logic [7:0] d, input logic pbad, input logic stop);
        if (!stop) m_ferr = 1;
        else if (pbad) m_perr = 1;
        else if (m_q.size() == DEPTH) m_ovf = 1;
        else m_q.push_back(d);
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_ovf = 0; m_perr = 0; m_ferr = 0; m_irq_en = 0;
    endfunction

    task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [7:0] d,
                           input logic c, input logic [7:0] e, input string nm);
        sb_t s;
        sb_t junk;
        logic got;
        s.chk = c; s.exp = e; s.nm = nm;
        sb_q.push_back(s);
        adr = a; we = w; wdat = d; stb = 1;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = ack;
        end
        stb = 0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ack: got 0 expected 1 within 8 cycles", nm);
            junk = sb_q.pop_back();
        end
    endtask

    task automatic wb_read(input logic [1:0] a, input string nm);
        logic [7:0] e;
        e = (a == 0) ? ((m_q.size() != 0) ? m_q.pop_front() : 8'h00) :
            (a == 1) ? m_status() :
            (a == 2) ? 8'(m_q.size()) : 8'h00;
        wb_xfer(a, 0, 8'h00, 1, e, nm);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        wb_xfer(a, 1, d, 0, 8'h00, "write");
        if (a == 1) begin
            m_irq_en = d[7];
            if (d[2]) m_ovf = 0;
            if (d[3]) m_perr = 0;
            if (d[4]) m_ferr = 0;
        end
        if (a == 3) m_q.delete();
    endtask

    task automatic ps2_bit(input logic b);
        ps2_d = b;
        cyc(H);
        ps2_c = 0;
        cyc(4);
        irq4 = irq;
        cyc(H - 4);
        ps2_c = 1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbad, input logic stop);
        ps2_bit(0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d ^ pbad);
        ps2_bit(stop);
        ps2_d = 1;
        cyc(6);
        m_frame(d, pbad, stop);
    endtask

    task automatic send_bits(input int n);
        ps2_bit(0);
        for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_d = 1;
    endtask

    task automatic send_timeout(input int n);
        send_bits(n);
        cyc(TO + 60);
        m_ferr = 1;
    endtask

    initial begin
        cyc(3);
        chk("reset_dat", rdat, 8'h00);
        chk("reset_ack", ack, 0);
        chk("reset_irq", irq, 0);
        rst = 0;
        cyc(3);
        wb_read(1, "reset_status");

        send_frame(8'h1C, 0, 1);
        wb_read(1, "s1c_status");
        wb_read(2, "s1c_count");
        wb_read(0, "s1c_byte");
        wb_read(1, "s1c_status_empty");
        wb_read(0, "s1c_empty_read");

        send_frame(8'hF0, 1, 1);
        wb_read(1, "perr_status");
        wb_read(2, "perr_count");
        wb_write(1, 8'h08);
        wb_read(1, "perr_cleared");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1);
        wb_read(1, "ovf_status");
        wb_read(2, "ovf_count");
        for (int i = 0; i < 9; i++) wb_read(0, "ovf_drain");
        wb_write(1, 8'h04);

        send_timeout(4);
        wb_read(1, "tmo_status");
        wb_read(2, "tmo_count");
        wb_write(1, 8'h10);
        send_frame(8'h55, 0, 1);
        wb_read(0, "tmo_next_byte");

        wb_write(1, 8'h80);
        chk("irq_idle", irq, 0);
        send_frame(8'h12, 0, 1);
        chk("irq_rise", irq4, 1);
        wb_read(0, "irq_byte");
        cyc(1);
        chk("irq_drop", irq, 0);

        for (int i = 0; i < 3; i++) send_frame(8'hA0 + 8'(i), 0, 1);
        chk("irq_three", irq, 1);
        wb_write(3, 8'h5A);
        wb_read(2, "flush_count");
        chk("flush_irq", irq, 0);

        send_bits(5);
        rst = 1;
        #1;
        chk("midrst_dat", rdat, 8'h00);
        chk("midrst_ack", ack, 0);
        chk("midrst_irq", irq, 0);
        cyc(2);
        rst = 0;
        m_reset();
        cyc(3);
        wb_read(1, "postrst_status");
        send_frame(8'h3A, 0, 1);
        wb_read(2, "postrst_count");
        wb_read(0, "postrst_byte");

        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op <= 4) begin
                int e;
                e = $urandom_range(0, 7);
                send_frame(8'($urandom), e == 0, e != 1);
            end else if (op <= 6) begin
                wb_read(2'($urandom_range(0, 3)), "rnd_read");
            end else if (op == 7) begin
                wb_write(1, 8'($urandom));
            end else if (op == 8) begin
                wb_write(2'($urandom_range(0, 3)), 8'($urandom));
            end else if (op == 9) begin
                send_timeout($urandom_range(0, 9));
            end else begin
                wb_read(0, "rnd_pop");
            end
            chk("rnd_irq", irq, 8'(m_irq_en && m_q.size() != 0));
        end
        wb_read(1, "final_status");
        wb_read(2, "final_count");

        cyc(4);
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
